// File: rtl/gcd_core_8.sv
// -----------------------------------------------------------------------------
// gcd_core_8
//
// Sequential subtractive-Euclid GCD engine. Accepts an unsigned operand pair
// over a valid/ready handshake, repeatedly subtracts the smaller operand from
// the larger until one is zero or both are equal, then presents the GCD and
// the number of subtraction steps taken over a second valid/ready handshake.
//
// State table:
//   state  | meaning
//   -------+---------------------------------------------------------------
//   S_IDLE | waiting for an operand pair; in_ready=1
//   S_CALC | iterating compare/subtract on A/B; busy=1
//   S_DONE | result held on gcd_out/iter_cnt; out_valid=1 until out_ready
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair on a_in/b_in is valid
//   in_ready   block can accept an operand pair (IDLE only)
//   a_in       operand A, unsigned
//   b_in       operand B, unsigned
//   out_valid  gcd_out/iter_cnt hold a valid result
//   out_ready  consumer takes the result
//   gcd_out    GCD result, unsigned
//   iter_cnt   subtraction steps used for this result
//   busy       high while iterating
// -----------------------------------------------------------------------------
module gcd_core_8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gcd_out,
    output logic [WIDTH-1:0] iter_cnt,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] gcd_q;
    logic [WIDTH-1:0] cnt_q;

    // Datapath: compare and both subtraction directions. Only the direction
    // selected by a_gt_b is ever written back, so neither can underflow.
    logic             a_zero;
    logic             b_zero;
    logic             a_eq_b;
    logic             a_gt_b;
    logic [WIDTH-1:0] a_minus_b;
    logic [WIDTH-1:0] b_minus_a;

    always_comb begin
        a_zero    = (a_q == '0);
        b_zero    = (b_q == '0);
        a_eq_b    = (a_q == b_q);
        a_gt_b    = (a_q > b_q);
        a_minus_b = a_q - b_q;
        b_minus_a = b_q - a_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            gcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // in_ready is exactly (state == IDLE), so in_valid alone
                    // completes the handshake here.
                    if (in_valid) begin
                        a_q     <= a_in;
                        b_q     <= b_in;
                        cnt_q   <= '0;
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (a_zero) begin
                        gcd_q   <= b_q;
                        state_q <= S_DONE;
                    end else if (b_zero) begin
                        gcd_q   <= a_q;
                        state_q <= S_DONE;
                    end else if (a_eq_b) begin
                        gcd_q   <= a_q;
                        state_q <= S_DONE;
                    end else if (a_gt_b) begin
                        a_q   <= a_minus_b;
                        cnt_q <= cnt_q + CNT_ONE;
                    end else begin
                        b_q   <= b_minus_a;
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_DONE: begin
                    // Result registers are left untouched on exit so the
                    // last result stays readable while idle.
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_CALC);
    assign out_valid = (state_q == S_DONE);
    assign gcd_out   = gcd_q;
    assign iter_cnt  = cnt_q;

endmodule

// File: doc/gcd_core_8.md
Name: gcd_core_8

Overview:
- Sequential subtractive-Euclid GCD engine for the GCD coursework design.
- Owns the operand registers A and B, the compare/subtract datapath and the controller FSM.
- Drives the operand-select muxes each cycle: external operand on load, difference on iterate.
- Valid/ready handshake on input and output; reports the number of subtraction steps taken.

Parameters:
WIDTH, 8, operand/result width in bits; the iteration counter is also WIDTH bits wide.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand pair on a_in/b_in is valid.
in_ready  output  1  block can accept an operand pair (IDLE only).
a_in  input  WIDTH  operand A, unsigned.
b_in  input  WIDTH  operand B, unsigned.
out_valid  output  1  gcd_out/iter_cnt hold a valid result.
out_ready  input  1  consumer takes the result.
gcd_out  output  WIDTH  GCD result, unsigned.
iter_cnt  output  WIDTH  subtraction steps used for this result.
busy  output  1  high in CALC.

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous and active-low.
- While rst_n is low: state=IDLE, A=B=0, gcd_out=0, iter_cnt=0, out_valid=0, busy=0, in_ready=1.
- Asserting reset mid-CALC or in DONE aborts the operation. The result is discarded and no out_valid pulse is produced.
- States: IDLE, CALC, DONE. Outputs are decoded from registered state: in_ready=(IDLE), busy=(CALC), out_valid=(DONE).
- IDLE -> CALC: on a clock edge with in_valid&in_ready.
  - A<=a_in, B<=b_in, iter_cnt<=0.
  - Operands are sampled only at this edge.
- CALC, evaluated on each edge in priority order:
  - A==0: gcd_out<=B, go DONE.
  - else B==0: gcd_out<=A, go DONE.
  - else A==B: gcd_out<=A, go DONE.
  - else A>B: A<=A-B, iter_cnt+=1.
  - else: B<=B-A, iter_cnt+=1.
- Arithmetic rules:
  - Subtraction is unsigned WIDTH-bit; by construction it never underflows.
  - iter_cnt never exceeds 2^WIDTH-2, so it never wraps.
- Latency: with N subtraction steps, out_valid rises N+1 edges after the acceptance edge.
  - Examples: (12,8): N=2, 3 edges. (255,1): N=254, 255 edges.
- DONE:
  - gcd_out and iter_cnt stay stable while out_valid=1.
  - On an edge with out_ready=1, go IDLE. out_valid falls and gcd_out/iter_cnt keep their values.
  - With out_ready=0 the block holds DONE indefinitely.
- Throughput: no same-cycle bypass. The earliest next acceptance is the edge after the DONE->IDLE edge.
- in_valid in CALC or DONE is ignored; operands are not captured and the in-flight result is not disturbed.
- out_ready outside DONE has no effect.
- Zero cases: gcd(0,0)=0, gcd(x,0)=gcd(0,x)=x, each with iter_cnt=0 and 1-edge latency.

Test Plan:
- Reset, then a_in=12, b_in=8, in_valid 1 cycle, out_ready=1 -> out_valid high exactly 3 edges after acceptance; gcd_out=4, iter_cnt=2; back in IDLE with in_ready=1 one edge later.
- a_in=255, b_in=1 -> gcd_out=1, iter_cnt=254, out_valid after 255 edges; busy high throughout CALC. Then a_in=1, b_in=255 -> same result.
- Zero and equal operands: (0,0) -> gcd_out=0, iter_cnt=0, latency 1; (7,0) -> 7; (0,9) -> 9; (13,13) -> 13, iter_cnt=0.
- Backpressure: (48,18) with out_ready=0 for 10 cycles -> out_valid stays 1 with gcd_out=6, iter_cnt=4 stable; a new in_valid with (9,3) during DONE is ignored; out_ready=1 -> IDLE.
- Busy overlap: (100,75) accepted; in_valid with (5,5) pulsed during CALC -> result is still 25, iter_cnt=3; (5,5) is not processed.
- Reset mid-CALC: (255,1) accepted, rst_n pulled low at edge 50 (asynchronous, mid-cycle) -> outputs are at reset values immediately; no out_valid afterwards. After release, (12,8) completes normally with gcd_out=4.
